// File: rtl/prbs_pkg.sv
// prbs_pkg -- shared definitions for the PRBS8 checker slice.
//   prbs_state_e        : acquisition/lock FSM state encoding
//   PRBS_POLY_DEFAULT   : Galois feedback mask for x^8+x^6+x^5+x^4+1
//   LOCK_GOOD_DEFAULT   : consecutive matches after seeding needed to lock
//   UNLOCK_BAD_DEFAULT  : consecutive mismatches while locked needed to unlock
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_TRACK    = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_LOSING   = 2'd3
  } prbs_state_e;

  localparam logic [7:0] PRBS_POLY_DEFAULT  = 8'hB8;
  localparam int         LOCK_GOOD_DEFAULT  = 5;
  localparam int         UNLOCK_BAD_DEFAULT = 3;

endpackage

// File: rtl/prbs8_next.sv
// prbs8_next -- one step of the 8-bit Galois PRBS register.
//   cur : current 8-bit state (8'h00 is not part of the sequence)
//   nxt : successor state, period 255 for the default polynomial
// Purely combinational so generator and checker can share it.
module prbs8_next
  import prbs_pkg::*;
#(
  parameter logic [7:0] POLY = PRBS_POLY_DEFAULT
) (
  input  logic [7:0] cur,
  output logic [7:0] nxt
);

  assign nxt = {1'b0, cur[7:1]} ^ (cur[0] ? POLY : 8'h00);

endmodule

// File: rtl/prbs8_sync_checker.sv
// prbs8_sync_checker -- acquires lock on an 8-bit PRBS word stream and
// counts word errors once locked.
//   clk          : single rising-edge clock
//   i_rst        : synchronous active-high reset, highest priority
//   i_soft_reset : synchronous re-acquire request (keeps the error count)
//   i_valid      : qualifies i_data, one word per high cycle
//   i_data       : received PRBS word
//   o_lock       : registered lock indication
//   o_err_cnt    : saturating mismatch count while locked
// Optional feature: define PRBS_ERR_CNT_EN to build the error counter;
// without it o_err_cnt is tied to zero and lock behaviour is unchanged.
module prbs8_sync_checker
  import prbs_pkg::*;
#(
  parameter logic [7:0] POLY       = PRBS_POLY_DEFAULT,
  parameter int         LOCK_GOOD  = LOCK_GOOD_DEFAULT,
  parameter int         UNLOCK_BAD = UNLOCK_BAD_DEFAULT,
  parameter int         ERR_W      = 16
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_soft_reset,
  input  logic             i_valid,
  input  logic [7:0]       i_data,
  output logic             o_lock,
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
  localparam int BAD_W  = $clog2(UNLOCK_BAD + 1);

  localparam logic [GOOD_W:0]  LOCK_GOOD_C  = (GOOD_W + 1)'(LOCK_GOOD);
  localparam logic [BAD_W:0]   UNLOCK_BAD_C = (BAD_W + 1)'(UNLOCK_BAD);
  localparam logic [BAD_W:0]   BAD_ONE_C    = {{BAD_W{1'b0}}, 1'b1};

  prbs_state_e        state_r, state_nxt_s;
  logic [7:0]         exp_r, exp_nxt_s;
  logic [GOOD_W-1:0]  good_r, good_nxt_s;
  logic [BAD_W-1:0]   bad_r, bad_nxt_s;
  logic               lock_r;

  logic [7:0]         next_data_s;
  logic [7:0]         next_exp_s;
  logic               match_s;
  logic [GOOD_W:0]    good_inc_s;
  logic [BAD_W:0]     bad_inc_s;
  logic               in_lock_s;

  // Seed candidate from the received word, and flywheel step of the
  // expected word; both reuse the generator's next() block.
  prbs8_next #(.POLY(POLY)) u_next_data (.cur(i_data), .nxt(next_data_s));
  prbs8_next #(.POLY(POLY)) u_next_exp  (.cur(exp_r),  .nxt(next_exp_s));

  assign match_s    = (i_data == exp_r);
  assign good_inc_s = {1'b0, good_r} + {{GOOD_W{1'b0}}, 1'b1};
  assign bad_inc_s  = {1'b0, bad_r} + {{BAD_W{1'b0}}, 1'b1};
  assign in_lock_s  = (state_r == ST_LOCKED) || (state_r == ST_LOSING);

  // State, expected word and run counters; only i_rst acts here.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_r <= ST_UNLOCKED;
      exp_r   <= 8'h00;
      good_r  <= {GOOD_W{1'b0}};
      bad_r   <= {BAD_W{1'b0}};
      lock_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      exp_r   <= exp_nxt_s;
      good_r  <= good_nxt_s;
      bad_r   <= bad_nxt_s;
      lock_r  <= (state_nxt_s == ST_LOCKED) || (state_nxt_s == ST_LOSING);
    end
  end

  // Next-state logic: soft reset, then per-valid-word acquisition/tracking.
  always_comb begin
    state_nxt_s = state_r;
    exp_nxt_s   = exp_r;
    good_nxt_s  = good_r;
    bad_nxt_s   = bad_r;
    if (i_soft_reset) begin
      state_nxt_s = ST_UNLOCKED;
      exp_nxt_s   = 8'h00;
      good_nxt_s  = {GOOD_W{1'b0}};
      bad_nxt_s   = {BAD_W{1'b0}};
    end else if (i_valid) begin
      case (state_r)
        ST_UNLOCKED: begin
          // An all-zero word cannot belong to the sequence, so never seed on it.
          if (i_data != 8'h00) begin
            exp_nxt_s   = next_data_s;
            good_nxt_s  = {GOOD_W{1'b0}};
            state_nxt_s = ST_TRACK;
          end else begin
            state_nxt_s = ST_UNLOCKED;
          end
        end
        ST_TRACK: begin
          if (match_s) begin
            exp_nxt_s = next_exp_s;
            if (good_inc_s == LOCK_GOOD_C) begin
              good_nxt_s  = {GOOD_W{1'b0}};
              bad_nxt_s   = {BAD_W{1'b0}};
              state_nxt_s = ST_LOCKED;
            end else begin
              good_nxt_s  = good_inc_s[GOOD_W-1:0];
            end
          end else if (i_data != 8'h00) begin
            // Reseed from the word that broke the run.
            exp_nxt_s   = next_data_s;
            good_nxt_s  = {GOOD_W{1'b0}};
            state_nxt_s = ST_TRACK;
          end else begin
            good_nxt_s  = {GOOD_W{1'b0}};
            state_nxt_s = ST_UNLOCKED;
          end
        end
        ST_LOCKED: begin
          // Flywheel: keep stepping exp, never reseed while locked.
          exp_nxt_s = next_exp_s;
          if (!match_s) begin
            if (BAD_ONE_C == UNLOCK_BAD_C) begin
              bad_nxt_s   = {BAD_W{1'b0}};
              state_nxt_s = ST_UNLOCKED;
            end else begin
              bad_nxt_s   = BAD_ONE_C[BAD_W-1:0];
              state_nxt_s = ST_LOSING;
            end
          end else begin
            state_nxt_s = ST_LOCKED;
          end
        end
        ST_LOSING: begin
          exp_nxt_s = next_exp_s;
          if (!match_s) begin
            if (bad_inc_s == UNLOCK_BAD_C) begin
              bad_nxt_s   = {BAD_W{1'b0}};
              state_nxt_s = ST_UNLOCKED;
            end else begin
              bad_nxt_s   = bad_inc_s[BAD_W-1:0];
              state_nxt_s = ST_LOSING;
            end
          end else begin
            bad_nxt_s   = {BAD_W{1'b0}};
            state_nxt_s = ST_LOCKED;
          end
        end
        default: begin
          state_nxt_s = ST_UNLOCKED;
          exp_nxt_s   = 8'h00;
          good_nxt_s  = {GOOD_W{1'b0}};
          bad_nxt_s   = {BAD_W{1'b0}};
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  assign o_lock = lock_r;

`ifdef PRBS_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt_r;
  logic             err_inc_s;

  // Every mismatching word while locked counts, including the one that drops lock.
  assign err_inc_s = i_valid && !i_soft_reset && in_lock_s && !match_s;

  // Saturating error counter; survives soft reset, cleared only by i_rst.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      err_cnt_r <= {ERR_W{1'b0}};
    end else if (err_inc_s && (err_cnt_r != {ERR_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + {{(ERR_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign o_err_cnt = err_cnt_r;
`else
  logic unused_lock_s;
  assign unused_lock_s = in_lock_s;
  assign o_err_cnt     = {ERR_W{1'b0}};
`endif

endmodule
